// File: rtl/vga_frame_source.sv
// rtl/vga_frame_source.sv - VGA timing generator with built-in test patterns
//
// Purpose: free-running horizontal/vertical counters produce VGA sync and
// blanking, plus one of four test patterns (colour bars, checkerboard,
// scrolling grey ramp, solid colour). Every output is registered, so the
// outputs describe the counter state of the previous cycle.
//
// Ports:
//   VGA_CLK       in   1   pixel clock
//   reset         in   1   asynchronous active-high reset
//   pattern_sel   in   2   test pattern select (sampled once per frame)
//   solid_rgb     in  24   {R,G,B} for the solid pattern (sampled once per frame)
//   oVGA_R/G/B    out  8   pixel colour, zero while blanked
//   oVGA_HS/VS    out  1   horizontal/vertical sync, active-low
//   oVGA_SYNC_N   out  1   constant 0
//   oVGA_BLANK_N  out  1   high only on active pixels
//   pixel_x       out 11   column of the pixel on the colour outputs
//   pixel_y       out 10   line of the pixel on the colour outputs
//   frame_start   out  1   pulse with pixel (0,0) on the outputs
//   frame_cnt     out  8   completed-frame counter
module vga_frame_source #(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 480,
  parameter int H_FP   = 40,
  parameter int H_SYNC = 48,
  parameter int H_BP   = 40,
  parameter int V_FP   = 13,
  parameter int V_SYNC = 3,
  parameter int V_BP   = 29
) (
  input  logic        VGA_CLK,
  input  logic        reset,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic [7:0]  oVGA_R,
  output logic [7:0]  oVGA_G,
  output logic [7:0]  oVGA_B,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_SYNC_N,
  output logic        oVGA_BLANK_N,
  output logic [10:0] pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam int H_TOTAL = WIDTH + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = HEIGHT + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_ACT    = 11'(WIDTH);
  localparam logic [10:0] H_SYNC_S = 11'(WIDTH + H_FP);
  localparam logic [10:0] H_SYNC_E = 11'(WIDTH + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(HEIGHT);
  localparam logic [9:0]  V_SYNC_S = 10'(HEIGHT + V_FP);
  localparam logic [9:0]  V_SYNC_E = 10'(HEIGHT + V_FP + V_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // Guard against a zero bar width for very narrow configurations.
  localparam logic [10:0] BAR_W    = 11'((WIDTH >= 8) ? (WIDTH / 8) : 1);

  // Timing counters and per-frame shadow state
  logic [10:0] r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic [1:0]  r_pat;
  logic [23:0] r_solid;
  logic [7:0]  r_frame_cnt;

  // Registered outputs
  logic [7:0]  r_red, r_grn, r_blu;
  logic        r_hs, r_vs, r_blank_n, r_frame_start;
  logic [10:0] r_px;
  logic [9:0]  r_py;

  logic        w_h_last, w_v_last, w_frame_end, w_active;
  logic        w_h_sync, w_v_sync;
  logic [2:0]  w_bar_idx;
  logic [7:0]  w_grey;
  logic [23:0] w_rgb;

  assign w_h_last    = (r_h_cnt == H_LAST);
  assign w_v_last    = (r_v_cnt == V_LAST);
  assign w_frame_end = w_h_last && w_v_last;
  assign w_active    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_h_sync    = (r_h_cnt >= H_SYNC_S) && (r_h_cnt < H_SYNC_E);
  assign w_v_sync    = (r_v_cnt >= V_SYNC_S) && (r_v_cnt < V_SYNC_E);
  assign w_bar_idx   = 3'(r_h_cnt / BAR_W);
  assign w_grey      = r_h_cnt[7:0] + r_frame_cnt;

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 11'd1;
    end
  end

  // Pattern inputs are only taken at the last pixel of a frame, so a frame
  // is always drawn with one consistent pattern. frame_cnt steps at the same
  // edge, so the grey ramp scrolls exactly once per frame.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      r_pat       <= '0;
      r_solid     <= '0;
      r_frame_cnt <= '0;
    end else if (w_frame_end) begin
      r_pat       <= pattern_sel;
      r_solid     <= solid_rgb;
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  always_comb begin
    w_rgb = '0;
    case (r_pat)
      2'd0: w_rgb = {{8{w_bar_idx[2]}}, {8{w_bar_idx[1]}}, {8{w_bar_idx[0]}}};
      2'd1: w_rgb = (r_h_cnt[5] ^ r_v_cnt[5]) ? 24'hFFFFFF : 24'h000000;
      2'd2: w_rgb = {w_grey, w_grey, w_grey};
      default: w_rgb = r_solid;
    endcase
    if (!w_active) begin
      w_rgb = '0;
    end
  end

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      r_red         <= '0;
      r_grn         <= '0;
      r_blu         <= '0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank_n     <= 1'b0;
      r_px          <= '0;
      r_py          <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_red         <= w_rgb[23:16];
      r_grn         <= w_rgb[15:8];
      r_blu         <= w_rgb[7:0];
      r_hs          <= !w_h_sync;
      r_vs          <= !w_v_sync;
      r_blank_n     <= w_active;
      r_px          <= r_h_cnt;
      r_py          <= r_v_cnt;
      r_frame_start <= (r_h_cnt == 11'd0) && (r_v_cnt == 10'd0);
    end
  end

  assign oVGA_R       = r_red;
  assign oVGA_G       = r_grn;
  assign oVGA_B       = r_blu;
  assign oVGA_HS      = r_hs;
  assign oVGA_VS      = r_vs;
  assign oVGA_SYNC_N  = 1'b0;
  assign oVGA_BLANK_N = r_blank_n;
  assign pixel_x      = r_px;
  assign pixel_y      = r_py;
  assign frame_start  = r_frame_start;
  assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_vga_frame_source.sv
// tb/tb_vga_frame_source.sv - directed bench for vga_frame_source
//
// Main instance uses a reduced geometry (256x34 active, 272x38 total,
// 10336 cycles per frame); a tiny instance (11x4 total, 44 cycles per
// frame) exercises the frame counter wrap.
module tb_vga_frame_source;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] solid_rgb = 24'h0;

  logic [7:0]  r, g, b;
  logic        hs, vs, sync_n, blank_n, fs;
  logic [10:0] px;
  logic [9:0]  py;
  logic [7:0]  fcnt;

  logic [1:0]  t_pat = 2'd0;
  logic [23:0] t_rgb = 24'h0;
  logic [7:0]  t_r, t_g, t_b;
  logic        t_hs, t_vs, t_sync_n, t_blank_n, t_fs;
  logic [10:0] t_px;
  logic [9:0]  t_py;
  logic [7:0]  t_fcnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int c0, c1, lo, n;

  always #5 clk = ~clk;

  vga_frame_source #(
    .WIDTH(256), .HEIGHT(34), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .VGA_CLK(clk), .reset(rst), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .oVGA_R(r), .oVGA_G(g), .oVGA_B(b), .oVGA_HS(hs), .oVGA_VS(vs),
    .oVGA_SYNC_N(sync_n), .oVGA_BLANK_N(blank_n), .pixel_x(px), .pixel_y(py),
    .frame_start(fs), .frame_cnt(fcnt)
  );

  vga_frame_source #(
    .WIDTH(8), .HEIGHT(1), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) tiny (
    .VGA_CLK(clk), .reset(rst), .pattern_sel(t_pat), .solid_rgb(t_rgb),
    .oVGA_R(t_r), .oVGA_G(t_g), .oVGA_B(t_b), .oVGA_HS(t_hs), .oVGA_VS(t_vs),
    .oVGA_SYNC_N(t_sync_n), .oVGA_BLANK_N(t_blank_n), .pixel_x(t_px), .pixel_y(t_py),
    .frame_start(t_fs), .frame_cnt(t_fcnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_pix(input string tag, input int x, input int y, input int limit);
    int k = 0;
    while (!(px == 11'(x) && py == 10'(y)) && k < limit) begin
      tick();
      k++;
    end
    check(tag, 32'(px == 11'(x) && py == 10'(y)), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_px"}, 32'(px), 32'd0);
    check({tag, "_py"}, 32'(py), 32'd0);
    check({tag, "_hs"}, 32'(hs), 32'd1);
    check({tag, "_vs"}, 32'(vs), 32'd1);
    check({tag, "_blank"}, 32'(blank_n), 32'd0);
    check({tag, "_sync"}, 32'(sync_n), 32'd0);
    check({tag, "_rgb"}, 32'({r, g, b}), 32'h0);
    check({tag, "_fs"}, 32'(fs), 32'd0);
    check({tag, "_fcnt"}, 32'(fcnt), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");

    @(negedge clk);
    rst = 1'b0;
    tick();
    c0 = cyc;
    check("first_blank", 32'(blank_n), 32'd1);
    check("first_px", 32'(px), 32'd0);
    check("first_py", 32'(py), 32'd0);
    check("first_fs", 32'(fs), 32'd1);
    check("first_rgb", 32'({r, g, b}), 32'h000000);
    tick();
    check("fs_one_cycle", 32'(fs), 32'd0);

    // colour bars, 32 pixels wide
    wait_pix("reach_40_0", 40, 0, 400);
    check("bar1", 32'({r, g, b}), 32'h0000FF);
    wait_pix("reach_100_0", 100, 0, 400);
    check("bar3", 32'({r, g, b}), 32'h00FFFF);
    wait_pix("reach_160_0", 160, 0, 400);
    check("bar5", 32'({r, g, b}), 32'hFF00FF);
    wait_pix("reach_255_0", 255, 0, 400);
    check("bar7", 32'({r, g, b}), 32'hFFFFFF);
    check("bar7_blank", 32'(blank_n), 32'd1);
    tick();
    check("x256_blank", 32'(blank_n), 32'd0);
    check("x256_rgb", 32'({r, g, b}), 32'h0);

    // horizontal sync at x 260..267
    wait_pix("reach_259_0", 259, 0, 400);
    check("hs_before", 32'(hs), 32'd1);
    tick();
    check("hs_start", 32'(hs), 32'd0);
    c1 = cyc;
    lo = 0;
    while (hs == 1'b0 && lo < 1000) begin
      lo++;
      tick();
    end
    check("hs_width", 32'(lo), 32'd8);
    check("hs_end_x", 32'(px), 32'd268);
    wait_pix("reach_260_1", 260, 1, 400);
    check("line_period", 32'(cyc - c1), 32'd272);

    // pattern change mid-frame: bars persist until the next frame
    wait_pix("reach_200_20", 200, 20, 8000);
    pattern_sel = 2'd1;
    wait_pix("reach_210_20", 210, 20, 400);
    check("bars_kept_a", 32'({r, g, b}), 32'hFFFF00);
    wait_pix("reach_100_30", 100, 30, 4000);
    check("bars_kept_b", 32'({r, g, b}), 32'h00FFFF);

    // vertical sync on lines 35..36
    wait_pix("reach_0_34", 0, 34, 2000);
    check("vs_before", 32'(vs), 32'd1);
    check("vblank", 32'(blank_n), 32'd0);
    wait_pix("reach_0_35", 0, 35, 400);
    lo = 0;
    while (vs == 1'b0 && lo < 2000) begin
      lo++;
      tick();
    end
    check("vs_width", 32'(lo), 32'd544);
    check("vs_end_y", 32'(py), 32'd37);

    // frame 1: checkerboard
    wait_pix("reach_f1", 0, 0, 20000);
    check("f1_fs", 32'(fs), 32'd1);
    check("frame_period", 32'(cyc - c0), 32'd10336);
    check("f1_fcnt", 32'(fcnt), 32'd1);
    check("chk_0_0", 32'({r, g, b}), 32'h000000);
    wait_pix("reach_32_0", 32, 0, 400);
    check("chk_32_0", 32'({r, g, b}), 32'hFFFFFF);
    wait_pix("reach_0_32", 0, 32, 12000);
    check("chk_0_32", 32'({r, g, b}), 32'hFFFFFF);
    wait_pix("reach_32_32", 32, 32, 400);
    check("chk_32_32", 32'({r, g, b}), 32'h000000);
    pattern_sel = 2'd3;
    solid_rgb   = 24'h12AB34;

    // frame 2: solid, colour change mid-frame deferred
    wait_pix("reach_f2", 0, 0, 20000);
    check("f2_fcnt", 32'(fcnt), 32'd2);
    check("solid_a", 32'({r, g, b}), 32'h12AB34);
    wait_pix("reach_10_5", 10, 5, 4000);
    solid_rgb = 24'h000000;
    wait_pix("reach_255_33", 255, 33, 12000);
    check("solid_b", 32'({r, g, b}), 32'h12AB34);
    tick();
    check("solid_hblank", 32'({r, g, b}), 32'h0);
    wait_pix("reach_5_36", 5, 36, 2000);
    check("solid_vblank", 32'({r, g, b}), 32'h0);

    // frame 3: new solid colour
    wait_pix("reach_f3", 0, 0, 20000);
    check("f3_fcnt", 32'(fcnt), 32'd3);
    check("f3_blank", 32'(blank_n), 32'd1);
    check("solid_c", 32'({r, g, b}), 32'h000000);
    pattern_sel = 2'd2;
    wait_pix("reach_128_10", 128, 10, 4000);
    check("solid_d", 32'({r, g, b}), 32'h000000);

    // frames 4/5: grey ramp
    wait_pix("reach_f4", 0, 0, 20000);
    check("f4_fcnt", 32'(fcnt), 32'd4);
    check("ramp_f4", 32'({r, g, b}), 32'h040404);
    tick();
    wait_pix("reach_f5", 0, 0, 20000);
    check("f5_fcnt", 32'(fcnt), 32'd5);
    wait_pix("reach_10_0", 10, 0, 400);
    check("ramp_10", 32'({r, g, b}), 32'h0F0F0F);
    wait_pix("reach_250_0", 250, 0, 400);
    check("ramp_250", 32'({r, g, b}), 32'hFFFFFF);
    tick();
    check("ramp_251", 32'({r, g, b}), 32'h000000);

    // asynchronous reset mid-line, then restart from (0,0)
    wait_pix("reach_200_20b", 200, 20, 8000);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("async");
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rel_px", 32'(px), 32'd0);
    check("rel_py", 32'(py), 32'd0);
    check("rel_blank", 32'(blank_n), 32'd1);
    check("rel_fs", 32'(fs), 32'd1);
    check("rel_fcnt", 32'(fcnt), 32'd0);
    wait_pix("reach_40_0b", 40, 0, 400);
    check("rel_bars", 32'({r, g, b}), 32'h0000FF);

    // frame counter wrap on the tiny instance
    n = 0;
    while (t_fcnt != 8'd255 && n < 12000) begin
      n++;
      tick();
    end
    check("tiny_reach_255", 32'(t_fcnt), 32'd255);
    n = 0;
    while (t_fcnt == 8'd255 && n < 100) begin
      n++;
      tick();
    end
    check("tiny_wrap", 32'(t_fcnt), 32'd0);
    tick();
    check("tiny_wrap_fs", 32'(t_fs), 32'd1);
    check("tiny_wrap_px", 32'(t_px), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
